// File: rtl/key_filter_2ch.sv
// Two-channel key conditioner: 2-flop sync, per-channel debounce FSM,
// registered active-high levels and one-cycle press flags.
module key_filter_2ch #(
  parameter int CNT_MAX = 999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_in,
  output logic       po_a,
  output logic       po_b,
  output logic [1:0] key_flag
);

  localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    P_FILT,
    DOWN,
    R_FILT
  } state_t;

  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] po;

  // Reset to released so a held key is re-filtered from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_t           st;
    state_t           st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             po_q;
    logic             po_nxt;
    logic             flag_q;
    logic             flag_nxt;
    logic             done;
    logic             p_acc;
    logic             r_acc;

    assign done  = (cnt == CNT_TOP);
    assign p_acc = (st == P_FILT) && !s2[i] && done;
    assign r_acc = (st == R_FILT) && s2[i] && done;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        po_q   <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        st     <= st_nxt;
        cnt    <= cnt_nxt;
        po_q   <= po_nxt;
        flag_q <= flag_nxt;
      end
    end

    // Counter clears on every state change, so no path can wrap it
    always_comb begin
      st_nxt  = st;
      cnt_nxt = '0;
      unique case (st)
        IDLE: begin
          if (!s2[i]) st_nxt = P_FILT;
        end
        P_FILT: begin
          if (s2[i])     st_nxt  = IDLE;
          else if (done) st_nxt  = DOWN;
          else           cnt_nxt = cnt + CNT_W'(1);
        end
        DOWN: begin
          if (s2[i]) st_nxt = R_FILT;
        end
        R_FILT: begin
          if (!s2[i])    st_nxt  = DOWN;
          else if (done) st_nxt  = IDLE;
          else           cnt_nxt = cnt + CNT_W'(1);
        end
        default: st_nxt = IDLE;
      endcase
    end

    always_comb begin
      po_nxt   = po_q;
      flag_nxt = 1'b0;
      unique case (1'b1)
        p_acc: begin
          po_nxt   = 1'b1;
          flag_nxt = 1'b1;
        end
        r_acc: po_nxt = 1'b0;
        default: ;
      endcase
    end

    assign po[i]       = po_q;
    assign key_flag[i] = flag_q;
  end

  assign po_a = po[0];
  assign po_b = po[1];

endmodule
